mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 2:1 data mux.
- Two requesters (A, B) present packets over valid/ready; the block owns the mux select and locks it for a whole packet (until `last`).
- Forwards beats through a one-entry registered output stage to a single downstream consumer.
- Sits between two producer blocks and one shared sink in the SoC datapath.

Parameters:
- WIDTH, 8, data width of each input and of the output.
- MAX_BEATS, 16, maximum beats per packet before forced release; must be at least 2.
- CNT_W, 5, beat-counter width; must satisfy 2^CNT_W > MAX_BEATS.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- a_valid  input  1  requester A beat valid.
- a_data  input  WIDTH  requester A data.
- a_last  input  1  final beat of A packet.
- a_ready  output  1  A beat accepted this cycle when a_valid & a_ready.
- b_valid  input  1  requester B beat valid.
- b_data  input  WIDTH  requester B data.
- b_last  input  1  final beat of B packet.
- b_ready  output  1  B beat accepted this cycle when b_valid & b_ready.
- y_valid  output  1  output beat valid (registered).
- y_data  output  WIDTH  output data (registered).
- y_last  output  1  output last flag (registered).
- y_ready  input  1  downstream accepts when y_valid & y_ready.
- sel  output  1  mux select: 0 = A, 1 = B; meaningful only while busy.
- busy  output  1  high in GRANT_A or GRANT_B.
- err_overrun  output  1  sticky; set on forced release.

Behaviour:
- Reset (async, rst=1): state=IDLE, prio=0 (A preferred), beat_cnt=0; y_valid=0, y_data=0, y_last=0, sel=0, busy=0, err_overrun=0, a_ready=0, b_ready=0.
- FSM states: IDLE, GRANT_A, GRANT_B.
- IDLE:
  - a_ready = b_ready = 0.
  - Only A valid -> GRANT_A. Only B valid -> GRANT_B.
  - Both valid -> GRANT_A if prio=0, else GRANT_B.
  - Neither valid -> stay in IDLE.
  - Arbitration costs exactly one cycle.
- Output stage:
  - slot_free = !y_valid | y_ready.
  - a_ready = (state==GRANT_A) & slot_free. b_ready = (state==GRANT_B) & slot_free.
  - sel = 1 in GRANT_B, 0 otherwise; registered with the state.
- Transfer:
  - On an accepted beat, y_data/y_last load the granted input next edge and y_valid=1.
  - If y_ready & y_valid with no load, y_valid clears next edge.
  - Simultaneous drain and load keeps y_valid=1 (full throughput).
- Latency and throughput: beat accepted at edge N is visible on y at cycle N+1. Throughput is 1 beat/cycle inside a packet; 1 bubble cycle between packets (IDLE).
- Beat counter:
  - beat_cnt increments per accepted beat while granted.
  - Clears on packet end or forced release.
- Packet end: accepted beat with last=1 -> IDLE next edge; prio = granted requester inverted (after A set 1, after B set 0).
- Forced release:
  - Triggers when the accepted beat has last=0 and beat_cnt==MAX_BEATS-1.
  - Beat is forwarded with y_last forced to 1.
  - err_overrun is set (cleared only by rst).
  - State goes to IDLE; prio flips as on a normal end.
- Grant persistence: a granted requester dropping valid mid-packet keeps the grant; there is no timeout on stalls.
- Backpressure: y_ready=0 holds y_* stable while y_valid=1; no data may be lost or duplicated.
- Reset mid-packet: everything returns to reset values immediately; the partial packet is discarded.
- Requester protocol: once a valid is asserted, data/last stay stable until accepted (requester obligation; not checked).

Test Plan:
- Reset then idle: rst pulse, no valids -> y_valid=0, busy=0, sel=0, a_ready=b_ready=0 for 10 cycles.
- Single A packet: A sends 0x11,0x22,0x33 (last on 0x33), y_ready=1 -> y shows 0x11,0x22,0x33 on consecutive cycles starting one cycle after the first accept; y_last only with 0x33; then IDLE, prio=1.
- Contention round-robin: A and B each hold 2-beat packets continuously -> A (0xA0,0xA1) first, one bubble, then B (0xB0,0xB1), then A again; sel tracks 0,1,0.
- Backpressure: B streams 0x01..0x04, y_ready toggles 1,0,0,1,... -> y_data holds while y_ready=0; b_ready=0 while the slot is full; output sequence is exactly 0x01..0x04 with no gaps or duplicates.
- Overrun: A sends MAX_BEATS=16 beats with last=0 -> 16th beat output with y_last=1, err_overrun=1, then B (waiting) is granted next.
- Async reset mid-packet: assert rst during beat 2 of a B packet, between clock edges -> y_valid, busy, b_ready drop to 0 immediately; after release, a new A packet transfers normally.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for two packet requesters sharing one 2:1 data mux.
// The grant is held for a whole packet; beats leave through a one-entry registered output slot.
module mux2_rr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    input  logic             y_ready,
    output logic             sel,
    output logic             busy,
    output logic             err_overrun
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT_A = 2'd1;
    localparam logic [1:0] S_GRANT_B = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             prio;
    logic [CNT_W-1:0] beat_cnt;

    logic             slot_free;
    logic             accept;
    logic             cur_last;
    logic [WIDTH-1:0] cur_data;
    logic             forced;
    logic             pkt_end;

    // Ready depends on the downstream handshake this cycle, so it stays combinational.
    assign slot_free = !y_valid || y_ready;
    assign a_ready   = (state == S_GRANT_A) && slot_free;
    assign b_ready   = (state == S_GRANT_B) && slot_free;

    assign accept   = (a_valid && a_ready) || (b_valid && b_ready);
    assign cur_last = (state == S_GRANT_B) ? b_last : a_last;
    assign cur_data = (state == S_GRANT_B) ? b_data : a_data;
    assign forced   = accept && !cur_last && (beat_cnt == LAST_CNT);
    assign pkt_end  = accept && (cur_last || forced);

    // Next-state: one arbitration cycle in IDLE, grant held until the packet ends.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (a_valid && (!b_valid || !prio)) begin
                    state_nxt = S_GRANT_A;
                end else if (b_valid) begin
                    state_nxt = S_GRANT_B;
                end
            end
            S_GRANT_A, S_GRANT_B: begin
                if (pkt_end) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            sel   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            sel   <= (state_nxt == S_GRANT_B);
            busy  <= (state_nxt != S_IDLE);
        end
    end

    // Round-robin priority and per-packet beat count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio        <= 1'b0;
            beat_cnt    <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (pkt_end) begin
                prio     <= (state == S_GRANT_A);
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (forced) begin
                err_overrun <= 1'b1;
            end
        end
    end

    // Output slot: load on accept, drain on downstream handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_last  <= 1'b0;
        end else if (accept) begin
            y_valid <= 1'b1;
            y_data  <= cur_data;
            y_last  <= cur_last || forced;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: vector table, directed corner sequences,
// and randomized traffic checked against a packet-level scoreboard.
module tb_mux2_rr_arbiter;

    localparam int unsigned MAX_BEATS = 16;

    logic       clk;
    logic       rst;
    logic       a_valid, a_last, a_ready;
    logic [7:0] a_data;
    logic       b_valid, b_last, b_ready;
    logic [7:0] b_data;
    logic       y_valid, y_last, y_ready;
    logic [7:0] y_data;
    logic       sel, busy, err_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    mux2_rr_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready),
        .sel(sel), .busy(busy), .err_overrun(err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, av;
        logic [7:0] ad;
        logic       al, bv;
        logic [7:0] bd;
        logic       bl, yr;
        logic       e_yv;
        logic [7:0] e_yd;
        logic       e_yl, e_busy, e_sel, e_ar, e_br;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic av, input logic [7:0] ad, input logic al,
                                input logic bv, input logic [7:0] bd, input logic bl, input logic yr,
                                input logic yv, input logic [7:0] yd, input logic yl,
                                input logic bs, input logic sl, input logic ar, input logic br);
        vec_t v;
        v.rst = r;  v.av = av; v.ad = ad; v.al = al; v.bv = bv; v.bd = bd; v.bl = bl; v.yr = yr;
        v.e_yv = yv; v.e_yd = yd; v.e_yl = yl; v.e_busy = bs; v.e_sel = sl; v.e_ar = ar; v.e_br = br;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        a_valid = 0; a_data = 0; a_last = 0;
        b_valid = 0; b_data = 0; b_last = 0;
        y_ready = 1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive_idle();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    vec_t tbl[$];
    logic [8:0] got[$];
    logic [8:0] expq[$];

    initial begin
        rst = 1;
        drive_idle();

        // ---------------- vector table ----------------
        tbl.push_back(mk(1, 0,8'h00,0, 0,8'h00,0, 1, 0,8'h00,0, 0,0,0,0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 1, 0,8'h00,0, 0,0,0,0));
        // single A packet 11,22,33
        tbl.push_back(mk(0, 1,8'h11,0, 0,8'h00,0, 1, 0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0, 1,8'h11,0, 0,8'h00,0, 1, 0,8'h00,0, 1,0,1,0));
        tbl.push_back(mk(0, 1,8'h22,0, 0,8'h00,0, 1, 1,8'h11,0, 1,0,1,0));
        tbl.push_back(mk(0, 1,8'h33,1, 0,8'h00,0, 1, 1,8'h22,0, 1,0,1,0));
        tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 1, 1,8'h33,1, 0,0,0,0));
        // priority now favours B
        tbl.push_back(mk(0, 1,8'h44,1, 1,8'h55,1, 1, 0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0, 1,8'h44,1, 1,8'h55,1, 1, 0,8'h00,0, 1,1,0,1));
        tbl.push_back(mk(0, 1,8'h44,1, 0,8'h00,0, 1, 1,8'h55,1, 0,0,0,0));
        tbl.push_back(mk(0, 1,8'h44,1, 0,8'h00,0, 1, 0,8'h00,0, 1,0,1,0));
        tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 1, 1,8'h44,1, 0,0,0,0));
        // contention from reset: A0 A1 | bubble | B0 B1 | bubble | A again
        tbl.push_back(mk(1, 0,8'h00,0, 0,8'h00,0, 1, 0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0, 1,8'hA0,0, 1,8'hB0,0, 1, 0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0, 1,8'hA0,0, 1,8'hB0,0, 1, 0,8'h00,0, 1,0,1,0));
        tbl.push_back(mk(0, 1,8'hA1,1, 1,8'hB0,0, 1, 1,8'hA0,0, 1,0,1,0));
        tbl.push_back(mk(0, 1,8'hA0,0, 1,8'hB0,0, 1, 1,8'hA1,1, 0,0,0,0));
        tbl.push_back(mk(0, 1,8'hA0,0, 1,8'hB0,0, 1, 0,8'h00,0, 1,1,0,1));
        tbl.push_back(mk(0, 1,8'hA0,0, 1,8'hB1,1, 1, 1,8'hB0,0, 1,1,0,1));
        tbl.push_back(mk(0, 1,8'hA0,0, 1,8'hB0,0, 1, 1,8'hB1,1, 0,0,0,0));
        tbl.push_back(mk(0, 1,8'hA0,0, 1,8'hB0,0, 1, 0,8'h00,0, 1,0,1,0));

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            rst = tbl[i].rst;
            a_valid = tbl[i].av; a_data = tbl[i].ad; a_last = tbl[i].al;
            b_valid = tbl[i].bv; b_data = tbl[i].bd; b_last = tbl[i].bl;
            y_ready = tbl[i].yr;
            @(negedge clk);
            check($sformatf("vec%0d_y_valid", i), 32'(y_valid), 32'(tbl[i].e_yv));
            check($sformatf("vec%0d_busy", i),    32'(busy),    32'(tbl[i].e_busy));
            check($sformatf("vec%0d_sel", i),     32'(sel),     32'(tbl[i].e_sel));
            check($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(tbl[i].e_ar));
            check($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].e_br));
            if (tbl[i].e_yv) begin
                check($sformatf("vec%0d_y_data", i), 32'(y_data), 32'(tbl[i].e_yd));
                check($sformatf("vec%0d_y_last", i), 32'(y_last), 32'(tbl[i].e_yl));
            end
        end

        // ---------------- backpressure: B streams 01..04 ----------------
        do_reset();
        begin
            int bi = 0;
            logic pv = 0, pr = 1;
            logic [7:0] pd = 0;
            got.delete();
            for (int c = 0; c < 60 && got.size() < 4; c++) begin
                @(posedge clk); #1;
                b_valid = (bi < 4); b_data = 8'(bi + 1); b_last = (bi == 3);
                y_ready = (c % 4 == 0) || (c % 4 == 3);
                @(negedge clk);
                if (pv && !pr) begin
                    check("bp_hold_valid", 32'(y_valid), 32'd1);
                    check("bp_hold_data", 32'(y_data), 32'(pd));
                end
                if (y_valid && !y_ready) check("bp_b_ready_low", 32'(b_ready), 32'd0);
                if (b_valid && b_ready) bi++;
                if (y_valid && y_ready) got.push_back({y_last, y_data});
                pv = y_valid; pr = y_ready; pd = y_data;
            end
            check("bp_count", 32'(got.size()), 32'd4);
            for (int i = 0; i < 4 && i < got.size(); i++)
                check($sformatf("bp_beat%0d", i), 32'(got[i]), 32'({(i == 3), 8'(i + 1)}));
        end

        // ---------------- overrun: A sends beats with no last, B waits ----------------
        do_reset();
        begin
            int ai = 0;
            logic bdone = 0;
            got.delete();
            check("ovr_err_clear", 32'(err_overrun), 32'd0);
            for (int c = 0; c < 200 && got.size() < 17; c++) begin
                @(posedge clk); #1;
                a_valid = 1; a_data = 8'(8'h60 + ai); a_last = 0;
                b_valid = !bdone; b_data = 8'hBB; b_last = 1;
                y_ready = 1;
                @(negedge clk);
                if (a_valid && a_ready) ai++;
                if (b_valid && b_ready) bdone = 1;
                if (y_valid && y_ready) got.push_back({y_last, y_data});
            end
            check("ovr_count", 32'(got.size()), 32'd17);
            if (got.size() >= 17) begin
                check("ovr_beat15_nolast", 32'(got[14]), 32'({1'b0, 8'h6E}));
                check("ovr_beat16_forced", 32'(got[15]), 32'({1'b1, 8'h6F}));
                check("ovr_then_b",        32'(got[16]), 32'({1'b1, 8'hBB}));
            end
            check("ovr_err_set", 32'(err_overrun), 32'd1);
        end

        // ---------------- async reset in the middle of a B packet ----------------
        do_reset();
        begin
            int bi = 0;
            for (int c = 0; c < 20 && bi < 1; c++) begin
                @(posedge clk); #1;
                b_valid = 1; b_data = 8'hC1; b_last = 0;
                @(negedge clk);
                if (b_valid && b_ready) bi++;
            end
            @(posedge clk); #1;
            b_data = 8'hC2;
            check("ar_pre_busy", 32'(busy), 32'd1);
            check("ar_pre_y_valid", 32'(y_valid), 32'd1);
            #2 rst = 1;
            #1;
            check("ar_y_valid", 32'(y_valid), 32'd0);
            check("ar_busy",    32'(busy),    32'd0);
            check("ar_b_ready", 32'(b_ready), 32'd0);
            check("ar_sel",     32'(sel),     32'd0);
            @(negedge clk);
            drive_idle();
            rst = 0;
            got.delete();
            begin
                int ai = 0;
                for (int c = 0; c < 30 && got.size() < 2; c++) begin
                    @(posedge clk); #1;
                    a_valid = (ai < 2); a_data = 8'(8'h5A + ai); a_last = (ai == 1);
                    @(negedge clk);
                    if (a_valid && a_ready) ai++;
                    if (y_valid && y_ready) got.push_back({y_last, y_data});
                end
            end
            check("ar_after_count", 32'(got.size()), 32'd2);
            if (got.size() >= 2) begin
                check("ar_after_b0", 32'(got[0]), 32'({1'b0, 8'h5A}));
                check("ar_after_b1", 32'(got[1]), 32'({1'b1, 8'h5B}));
            end
        end

        // ---------------- randomized traffic vs packet-level scoreboard ----------------
        do_reset();
        begin
            int rem[2] = '{0, 0};
            logic vld[2] = '{0, 0};
            logic [7:0] dat[2] = '{0, 0};
            logic lst[2] = '{0, 0};
            int owner = -1, last_owner = 1, pcnt = 0, exp_next = 0;
            logic exp_err = 0, pend = 0, stop_new = 0, forced, acc;
            logic [8:0] e;
            expq.delete();
            for (int c = 0; c < 5000; c++) begin
                @(posedge clk); #1;
                for (int r = 0; r < 2; r++) begin
                    if (!vld[r]) begin
                        if (rem[r] == 0 && !stop_new && $urandom_range(0, 3) == 0)
                            rem[r] = int'($urandom_range(1, 20));
                        if (rem[r] > 0 && $urandom_range(0, 3) != 0) begin
                            vld[r] = 1; dat[r] = 8'($urandom); lst[r] = (rem[r] == 1);
                        end
                    end
                end
                a_valid = vld[0]; a_data = dat[0]; a_last = lst[0];
                b_valid = vld[1]; b_data = dat[1]; b_last = lst[1];
                y_ready = stop_new ? 1'b1 : ($urandom_range(0, 3) != 0);
                @(negedge clk);
                check("rnd_err", 32'(err_overrun), 32'(exp_err));
                check("rnd_excl", 32'(a_ready & b_ready), 32'd0);
                if (!busy && (a_valid || b_valid)) begin
                    pend = 1;
                    exp_next = (a_valid && b_valid) ? (1 - last_owner) : (b_valid ? 1 : 0);
                end
                if (y_valid && y_ready) begin
                    if (expq.size() == 0) check("rnd_unexpected_beat", 32'(y_data), 32'hFFFF);
                    else begin
                        e = expq.pop_front();
                        check("rnd_y", 32'({y_last, y_data}), 32'(e));
                    end
                end
                for (int r = 0; r < 2; r++) begin
                    acc = (r == 0) ? (a_valid && a_ready) : (b_valid && b_ready);
                    if (acc) begin
                        if (owner < 0) begin
                            if (pend) check("rnd_grant", 32'(r), 32'(exp_next));
                            owner = r; pcnt = 0; pend = 0;
                        end else begin
                            check("rnd_owner", 32'(r), 32'(owner));
                        end
                        forced = !lst[r] && (pcnt == MAX_BEATS - 1);
                        expq.push_back({lst[r] | forced, dat[r]});
                        pcnt++;
                        if (lst[r] || forced) begin
                            last_owner = r; owner = -1;
                            if (forced) exp_err = 1;
                        end
                        vld[r] = 0; rem[r]--;
                    end
                end
                if (c >= 3000) stop_new = 1;
                if (stop_new && rem[0] == 0 && rem[1] == 0 && expq.size() == 0 && !y_valid) break;
            end
            check("rnd_drain", 32'(expq.size()), 32'd0);
            check("rnd_err_final", 32'(err_overrun), 32'(exp_err));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
